// File: rtl/fp_mac_sequencer_pkg.sv
// Shared types and constants for the FP MAC front-panel sequencer.
package fp_mac_seq_pkg;

  localparam int FP_W = 16;
  localparam logic [FP_W-1:0] ERR_CODE = 16'hDEAD;

  // Encoding doubles as the status LED bit index.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY_A = 3'd1,
    ENTRY_B = 3'd2,
    ISSUE   = 3'd3,
    WAIT    = 3'd4
  } state_e;

  function automatic logic [4:0] state_onehot(input state_e s);
    return 5'b00001 << s;
  endfunction

endpackage

// File: rtl/fp_mac_sequencer_if.sv
// Start/done handshake and operand/result bus between the sequencer and the MAC core.
interface fp_mac_sequencer_if;
  import fp_mac_seq_pkg::*;

  // mac_start is a one-cycle request with mac_a/mac_b held stable; the core answers
  // later with a one-cycle mac_done, mac_result valid only in that cycle. No backpressure.
  logic [FP_W-1:0] mac_a;
  logic [FP_W-1:0] mac_b;
  logic            mac_start;
  logic            mac_done;
  logic [FP_W-1:0] mac_result;

  modport master (output mac_a, mac_b, mac_start, input mac_done, mac_result);
  modport slave  (input mac_a, mac_b, mac_start, output mac_done, mac_result);

endinterface

// File: rtl/fp_mac_sequencer_keypad_scanner.sv
// 4x4 keypad column scanner with row synchronizer and per-round debounce.
module keypad_scanner
  import fp_mac_seq_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] key_row_i,
  output logic [3:0] key_col_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W = $clog2(DEB_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEB_SCANS);

  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [3:0]       row_s1_q, row_s2_q;
  logic             round_hit_q;
  logic [3:0]       round_code_q;
  logic [3:0]       last_code_q;
  logic [DEB_W-1:0] stable_q;
  logic             armed_q;
  logic             key_valid_q;
  logic [3:0]       key_code_q;

  logic             sample, round_end, hit_d, same;
  logic [1:0]       row_idx;
  logic [3:0]       code_now;
  logic [DEB_W-1:0] stable_nx;

  // Rows are sampled in the last cycle of each column slot, so the 2-flop sync has settled.
  always_comb begin
    sample    = (div_q == DIV_LAST);
    round_end = sample && (col_q == 2'd3);
    if      (!row_s2_q[0]) row_idx = 2'd0;
    else if (!row_s2_q[1]) row_idx = 2'd1;
    else if (!row_s2_q[2]) row_idx = 2'd2;
    else                   row_idx = 2'd3;
    hit_d    = round_hit_q || (row_s2_q != 4'hF);
    code_now = round_hit_q ? round_code_q : {row_idx, col_q};
    same     = hit_d && (stable_q != '0) && (code_now == last_code_q);
    if (!hit_d)                    stable_nx = '0;
    else if (!same)                stable_nx = DEB_W'(1);
    else if (stable_q == DEB_FULL) stable_nx = stable_q;
    else                           stable_nx = stable_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q        <= '0;
      col_q        <= '0;
      row_s1_q     <= '0;
      row_s2_q     <= '0;
      round_hit_q  <= 1'b0;
      round_code_q <= '0;
      last_code_q  <= '0;
      stable_q     <= '0;
      armed_q      <= 1'b1;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
    end else begin
      row_s1_q    <= key_row_i;
      row_s2_q    <= row_s1_q;
      key_valid_q <= 1'b0;
      if (sample) begin
        div_q <= '0;
        col_q <= col_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (round_end) begin
        round_hit_q <= 1'b0;
        stable_q    <= stable_nx;
        if (hit_d) last_code_q <= code_now;
        // A key is re-armed only by a complete round with no row low.
        if (!hit_d) begin
          armed_q <= 1'b1;
        end else if (armed_q && stable_nx == DEB_FULL) begin
          armed_q     <= 1'b0;
          key_valid_q <= 1'b1;
          key_code_q  <= code_now;
        end
      end else if (sample) begin
        round_hit_q  <= hit_d;
        round_code_q <= code_now;
      end
    end
  end

  assign key_col_o   = ~(4'b0001 << col_q);
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/fp_mac_sequencer.sv
// Front-panel sequencer: keypad operand entry, ns_button stepping, one MAC per ISSUE.
// Build option FP_SEQ_TIMEOUT_EN: abandon WAIT after TIMEOUT cycles and show ERR_CODE.
module fp_mac_sequencer
  import fp_mac_seq_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4,
  parameter int BTN_DEB   = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ns_button,
  input  logic [3:0]          key_row,
  output logic [3:0]          key_col,
  fp_mac_sequencer_if.master  mac,
  output logic [FP_W-1:0]     disp_value,
  output logic [4:0]          status_leds
);

  localparam int BTN_W = $clog2(BTN_DEB + 1);
  localparam logic [BTN_W-1:0] BTN_LAST = BTN_W'(BTN_DEB - 1);

  state_e state_q, state_d;
  logic [FP_W-1:0] mac_a_q, mac_b_q, result_q;
  logic            show_q;
  logic            btn_s1_q, btn_s2_q, btn_armed_q, ns_press_q;
  logic [BTN_W-1:0] btn_cnt_q;
  logic            key_valid, btn_level, timeout;
  logic [3:0]      key_code;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) u_scan (
    .clk_i       (clk),
    .rst_ni      (rst),
    .key_row_i   (key_row),
    .key_col_o   (key_col),
    .key_valid_o (key_valid),
    .key_code_o  (key_code)
  );

  // While armed we time a stable low; after a press we time a stable high to re-arm.
  assign btn_level = btn_armed_q ? ~btn_s2_q : btn_s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      btn_cnt_q   <= '0;
      btn_armed_q <= 1'b1;
      ns_press_q  <= 1'b0;
    end else begin
      btn_s1_q   <= ns_button;
      btn_s2_q   <= btn_s1_q;
      ns_press_q <= 1'b0;
      if (!btn_level) begin
        btn_cnt_q <= '0;
      end else if (btn_cnt_q == BTN_LAST) begin
        btn_cnt_q   <= '0;
        btn_armed_q <= ~btn_armed_q;
        ns_press_q  <= btn_armed_q;
      end else begin
        btn_cnt_q <= btn_cnt_q + 1'b1;
      end
    end
  end

`ifdef FP_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt_q;

  assign timeout = (state_q == WAIT) && (wait_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ns_press_q) state_d = ENTRY_A;
      ENTRY_A: if (ns_press_q) state_d = ENTRY_B;
      ENTRY_B: if (ns_press_q) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mac.mac_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shifts happen in the same cycle as a state advance, so a coincident key lands first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_a_q  <= '0;
      mac_b_q  <= '0;
      result_q <= '0;
      show_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ns_press_q) begin
          mac_a_q <= '0;
          mac_b_q <= '0;
          show_q  <= 1'b0;
        end
        ENTRY_A: if (key_valid) mac_a_q <= {mac_a_q[11:0], key_code};
        ENTRY_B: if (key_valid) mac_b_q <= {mac_b_q[11:0], key_code};
        WAIT: if (mac.mac_done) begin
          result_q <= mac.mac_result;
          show_q   <= 1'b1;
        end else if (timeout) begin
          result_q <= ERR_CODE;
          show_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mac.mac_start = (state_q == ISSUE);
    status_leds   = state_onehot(state_q);
    case (state_q)
      ENTRY_A:             disp_value = mac_a_q;
      ENTRY_B, ISSUE, WAIT: disp_value = mac_b_q;
      default:             disp_value = show_q ? result_q : '0;
    endcase
  end

  assign mac.mac_a = mac_a_q;
  assign mac.mac_b = mac_b_q;

endmodule
